// File: rtl/cape_et_gen.sv
// Stochastic-bitstream generator: expands latched binary values into per-channel
// bit streams whose 1-density equals value/2^p, using bit-reversed counter slices.
module cape_et_gen #(
    parameter int WIDTH      = 4,
    parameter int NUM_INPUTS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(WIDTH+1)-1:0]    prec,
    input  logic [WIDTH-1:0]              Bxs [NUM_INPUTS],
    output logic                          busy,
    output logic                          Xs_valid,
    output logic [NUM_INPUTS-1:0]         Xs,
    output logic                          done,
    output logic [NUM_INPUTS*WIDTH:0]     ones [NUM_INPUTS],
    output logic [NUM_INPUTS*WIDTH:0]     len
);

    localparam int PW = $clog2(WIDTH+1);
    localparam int CW = NUM_INPUTS*WIDTH+1;
    localparam logic [PW-1:0] P_MAX = PW'(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_reg, state_next;
    logic [CW-1:0]         cnt_reg;
    logic [PW-1:0]         p_reg;
    logic [PW-1:0]         p_next;
    logic [WIDTH-1:0]      bx_reg   [NUM_INPUTS];
    logic [CW-1:0]         ones_reg [NUM_INPUTS];
    logic [CW-1:0]         len_reg;
    logic [CW-1:0]         last_cnt;
    logic [NUM_INPUTS-1:0] xs_run;
    logic                  in_run;
    logic                  run_end;

    assign in_run   = (state_reg == RUN);
    assign busy     = (state_reg == RUN) || (state_reg == DONE);
    assign Xs_valid = in_run;
    assign done     = (state_reg == DONE);
    assign Xs       = in_run ? xs_run : '0;
    assign len      = len_reg;

    // Out-of-range precision (0 or above WIDTH) means full precision.
    assign p_next   = ((prec == '0) || (prec > P_MAX)) ? P_MAX : prec;
    assign last_cnt = (CW'(1) << (NUM_INPUTS * int'(p_reg))) - CW'(1);
    assign run_end  = (cnt_reg == last_cnt) || abort;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_ch
            logic [CW-1:0]    seg;
            logic [WIDTH-1:0] r;
            logic [WIDTH-1:0] bx_masked;

            // Channel gi owns counter bits [gi*p +: p]; reversing them spreads
            // consecutive counts evenly across the comparison range.
            always_comb begin
                seg       = cnt_reg >> (gi * int'(p_reg));
                r         = '0;
                bx_masked = '0;
                for (int b = 0; b < WIDTH; b++) begin
                    if (b < int'(p_reg))
                        r[WIDTH-1-b] = seg[b];
                    if (b >= WIDTH - int'(p_reg))
                        bx_masked[b] = bx_reg[gi][b];
                end
            end

            assign xs_run[gi] = (bx_masked > r);
            assign ones[gi]   = ones_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (run_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            p_reg     <= '0;
            len_reg   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                bx_reg[i]   <= '0;
                ones_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg <= '0;
                        p_reg   <= p_next;
                        len_reg <= '0;
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            bx_reg[i]   <= Bxs[i];
                            ones_reg[i] <= '0;
                        end
                    end
                end
                RUN: begin
                    len_reg <= len_reg + CW'(1);
                    for (int i = 0; i < NUM_INPUTS; i++)
                        ones_reg[i] <= ones_reg[i] + CW'(xs_run[i]);
                    if (!run_end)
                        cnt_reg <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cape_et_gen.sv
// Directed bench for cape_et_gen (WIDTH=4, NUM_INPUTS=2) with hand-computed results.
module tb_cape_et_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] prec;
    logic [3:0] Bxs [2];
    logic       busy;
    logic       Xs_valid;
    logic [1:0] Xs;
    logic       done;
    logic [8:0] ones [2];
    logic [8:0] len;

    int checks = 0;
    int errors = 0;
    int nvalid, n0, n1, ndone;

    always #5 clk = ~clk;

    cape_et_gen #(.WIDTH(4), .NUM_INPUTS(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prec(prec),
        .Bxs(Bxs), .busy(busy), .Xs_valid(Xs_valid), .Xs(Xs), .done(done),
        .ones(ones), .len(len)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; returns at the negedge of the first RUN cycle.
    task automatic do_start(input logic [3:0] b0, input logic [3:0] b1, input logic [2:0] p,
                            input logic with_abort);
        @(negedge clk);
        Bxs[0] = b0; Bxs[1] = b1; prec = p; start = 1'b1; abort = with_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        Bxs[0] = ~b0; Bxs[1] = ~b1; prec = 3'd1;
    endtask

    // Samples from the current negedge until done; returns at the DONE-cycle negedge.
    task automatic watch(input int abort_at, input int restart_at);
        bit fin = 0;
        nvalid = 0; n0 = 0; n1 = 0; ndone = 0;
        for (int c = 0; c < 1000 && !fin; c++) begin
            if (Xs_valid) begin
                nvalid++; n0 += int'(Xs[0]); n1 += int'(Xs[1]);
            end
            if (done) begin
                ndone++; fin = 1;
            end
            abort = (abort_at != 0) && Xs_valid && (nvalid == abort_at);
            if (restart_at != 0) begin
                start = Xs_valid && (nvalid == restart_at);
                if (start) begin Bxs[0] = 4'b0000; Bxs[1] = 4'b0000; prec = 3'd1; end
            end
            if (!fin) @(negedge clk);
        end
        abort = 1'b0;
        if (restart_at != 0) start = 1'b0;
        if (!fin) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input int e0, input int e1, input int elen);
        chk({tag, "_valid"}, nvalid, elen);
        chk({tag, "_done"},  ndone, 1);
        chk({tag, "_ones0"}, ones[0], e0);
        chk({tag, "_ones1"}, ones[1], e1);
        chk({tag, "_len"},   len, elen);
        chk({tag, "_xs0"},   n0, e0);
        chk({tag, "_xs1"},   n1, e1);
        @(negedge clk);
        chk({tag, "_pulse"}, {done, busy}, 2'b00);
        $display("%s: valid=%0d ones={%0d,%0d} len=%0d", tag, nvalid, ones[0], ones[1], len);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; prec = 3'd0;
        Bxs[0] = 4'd0; Bxs[1] = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", Xs_valid, 0);
        chk("rst_xs", Xs, 0);
        chk("rst_len", len, 0);
        chk("rst_ones0", ones[0], 0);
        rst = 1'b0;

        // Abort outside RUN is ignored.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        do_start(4'b1100, 4'b1000, 3'd4, 1'b0);
        watch(0, 0);
        check_result("full_p4", 192, 128, 256);

        // start+abort together in IDLE starts the stream.
        do_start(4'b1100, 4'b1000, 3'd2, 1'b1);
        watch(0, 0);
        check_result("p2", 12, 8, 16);

        do_start(4'b1100, 4'b1000, 3'd0, 1'b0);
        watch(0, 0);
        check_result("p0", 192, 128, 256);

        do_start(4'b1100, 4'b1000, 3'd7, 1'b0);
        watch(0, 0);
        check_result("p7", 192, 128, 256);

        // Abort on the 10th RUN cycle; first 10 counts give 8 and 10 ones.
        do_start(4'b1100, 4'b1000, 3'd4, 1'b0);
        watch(10, 0);
        check_result("abort10", 8, 10, 10);

        // Abort on the final cycle is ordinary completion.
        do_start(4'b1100, 4'b1000, 3'd2, 1'b0);
        watch(16, 0);
        check_result("abort_last", 12, 8, 16);

        // Mid-run start with new Bxs is ignored.
        do_start(4'b1100, 4'b1000, 3'd4, 1'b0);
        watch(0, 20);
        check_result("restart_ign", 192, 128, 256);

        // start held through DONE launches a new stream right after.
        do_start(4'b1100, 4'b1000, 3'd2, 1'b0);
        watch(0, 0);
        chk("hold_ones0", ones[0], 12);
        Bxs[0] = 4'b0100; Bxs[1] = 4'b1111; prec = 3'd2; start = 1'b1;
        @(negedge clk);
        chk("hold_idle", {busy, done}, 2'b00);
        @(negedge clk);
        chk("hold_run", {busy, Xs_valid}, 2'b11);
        start = 1'b0;
        watch(0, 0);
        check_result("hold_new", 4, 12, 16);

        // Reset at RUN cycle 50 clears everything; no done follows.
        do_start(4'b1100, 4'b1000, 3'd4, 1'b0);
        repeat (49) @(negedge clk);
        chk("pre_rst_len", len, 49);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_flags", {busy, Xs_valid, done}, 3'b000);
        chk("mid_rst_xs", Xs, 0);
        chk("mid_rst_len", len, 0);
        chk("mid_rst_ones", {ones[0], ones[1]}, 18'd0);
        @(negedge clk);
        chk("mid_rst_nodone", {busy, done}, 2'b00);
        do_start(4'b1100, 4'b1000, 3'd4, 1'b0);
        watch(0, 0);
        check_result("after_rst", 192, 128, 256);

        // Zero and all-ones values at full precision.
        do_start(4'b0000, 4'b1111, 3'd4, 1'b0);
        watch(0, 0);
        chk("ratio0", ones[0] * 16, 0 * len);
        chk("ratio1", ones[1] * 16, 15 * len);
        check_result("extremes", 0, 240, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cape_et_gen.md
CAPE_ET_GEN -- requirements
Module: cape_et_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning bits per binary input value.
REQ-002 SHALL have parameter NUM_INPUTS, default 2, meaning number of stochastic channels.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin a stream; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  early-termination request; sampled in RUN only.
REQ-007 SHALL have port prec  input  $clog2(WIDTH+1)  precision p, latched on accepted start.
REQ-008 SHALL have port Bxs  input  WIDTH x NUM_INPUTS (unpacked array)  binary values, latched on accepted start.
REQ-009 SHALL have port busy  output  1  high in RUN and DONE.
REQ-010 SHALL have port Xs_valid  output  1  high in every RUN cycle.
REQ-011 SHALL have port Xs  output  NUM_INPUTS  stochastic bits, one per channel.
REQ-012 SHALL have port done  output  1  one-cycle pulse in DONE.
REQ-013 SHALL have port ones  output  (NUM_INPUTS*WIDTH+1) x NUM_INPUTS  per-channel count of 1s emitted.
REQ-014 SHALL have port len  output  NUM_INPUTS*WIDTH+1  count of RUN cycles in the last stream.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on last cycle or abort, DONE->IDLE unconditionally.
REQ-016 On accepted start SHALL latch Bxs and effective precision p = prec, with prec=0 or prec>WIDTH mapped to WIDTH; clear cnt, ones, len.
REQ-017 start SHALL be ignored while busy; Bxs/prec changes after acceptance SHALL not affect the stream.
REQ-018 RUN SHALL last L = 2^(NUM_INPUTS*p) cycles, cnt counting 0..L-1, one per cycle.
REQ-019 For channel i SHALL form r_i = bit-reversal of cnt[i*p +: p], left-aligned in WIDTH bits (low WIDTH-p bits zero).
REQ-020 Xs[i] SHALL equal 1 iff (latched Bx_i with low WIDTH-p bits masked to 0) > r_i, during RUN; Xs SHALL be 0 outside RUN.
REQ-021 Xs and Xs_valid SHALL be decoded from registered state and cnt with zero extra latency (cycle k of RUN shows cnt=k).
REQ-022 Each RUN cycle SHALL increment len, and ones[i] when Xs[i]=1; values SHALL hold from DONE until next accepted start.
REQ-023 abort in a RUN cycle SHALL count that cycle, then enter DONE; abort on the last RUN cycle SHALL equal normal completion.
REQ-024 abort outside RUN SHALL be ignored.
REQ-025 start and abort together in IDLE SHALL start a stream (abort ignored).
REQ-026 cnt width SHALL be NUM_INPUTS*WIDTH+1 bits so L at p=WIDTH never wraps; ones[i] <= len <= L always.
REQ-027 Bx_i masked value 0 SHALL give Xs[i]=0 every cycle; Bx_i all-ones SHALL give ones[i] = L - L/2^p.

Reset
REQ-028 rst high at a clock edge SHALL force IDLE, cnt=0, busy=0, Xs_valid=0, Xs=0, done=0, ones=0, len=0, latched Bxs=0.
REQ-029 rst SHALL override start, abort and any in-progress stream (RUN or DONE) in the same edge; no done pulse follows.

Verification
REQ-030 WIDTH=4, NUM_INPUTS=2, Bxs={4'b1100,4'b1000}, prec=4 -> 256 valid cycles, done pulse once, ones={192,128}, len=256.
REQ-031 Same Bxs, prec=2 -> 16 valid cycles, ones={12,8}, len=16; prec=0 -> identical to prec=4.
REQ-032 prec=4 run, abort asserted in 10th RUN cycle -> done next cycle, len=10, ones[i] equal to 1s counted on Xs by bench.
REQ-033 start pulsed again mid-RUN with new Bxs -> ignored, original results; start held high through DONE -> new stream begins the cycle after DONE.
REQ-034 rst asserted mid-RUN at cycle 50 -> next cycle all outputs zero, IDLE; subsequent start runs full 256 cycles with correct counts.
REQ-035 Bxs={4'b0000,4'b1111}, prec=4 -> Xs[0] never 1, ones={0,240}; bench checks ones[i]/len against masked Bx_i/2^p exactly at full length.
